csi_capture_ctrl: RTL and testbench

//  Packet-level sequencer behind the short-preamble detector and the long-preamble detector.
//  - Arms on a short-preamble pulse, then waits a bounded time for a long-preamble pulse.
//  - Gates a fixed-length burst of samples to the CSI extraction path.
//  - Holds off, then pulses a flush reset to clear detector averaging state before re-arming.

---
 rtl/csi_capture_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_csi_capture_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csi_capture_ctrl
// Brief    : Packet sequencer: arm on short preamble, gate a fixed-length
//            sample burst after the long preamble, hold off, flush detectors.
// Revision : 1.0 - initial release
// ============================================================================
module csi_capture_ctrl #(
   parameter int LONG_TIMEOUT    = 320,
   parameter int CAPTURE_LEN     = 128,
   parameter int HOLDOFF         = 64,
   parameter int SYNC_RST_CYCLES = 4
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        enable_in,
   input  logic [31:0] sample_in,
   input  logic        sample_in_valid,
   input  logic        short_preamble_detected,
   input  logic        long_preamble_detected,
   output logic        sync_rst_out,
   output logic [31:0] capture_sample_out,
   output logic        capture_valid_out,
   output logic        capture_last_out,
   output logic        busy_out,
   output logic [2:0]  state_out,
   output logic [15:0] pkt_count_out,
   output logic [15:0] timeout_count_out
);

   localparam int C_MAX_A   = (LONG_TIMEOUT > CAPTURE_LEN) ? LONG_TIMEOUT : CAPTURE_LEN;
   localparam int C_MAX_B   = (HOLDOFF > SYNC_RST_CYCLES) ? HOLDOFF : SYNC_RST_CYCLES;
   localparam int C_CNT_MAX = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
   localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

   localparam logic [C_CNT_W-1:0] C_TMO_LAST  = C_CNT_W'(LONG_TIMEOUT - 1);
   localparam logic [C_CNT_W-1:0] C_CAP_LAST  = C_CNT_W'(CAPTURE_LEN - 1);
   localparam logic [C_CNT_W-1:0] C_HOLD_LAST = C_CNT_W'(HOLDOFF - 1);
   localparam logic [C_CNT_W-1:0] C_SYNC_LAST = C_CNT_W'(SYNC_RST_CYCLES - 1);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LONG = 3'd1,
      ST_CAPTURE   = 3'd2,
      ST_HOLDOFF   = 3'd3,
      ST_FLUSH     = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [C_CNT_W-1:0]   cnt_q, cnt_d;
   logic                 cnt_inc;
   logic [31:0]          data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 last_q, last_d;
   logic [15:0]          pkt_q, pkt_d;
   logic [15:0]          tmo_q, tmo_d;
   logic                 sync_q, sync_d;
   logic                 busy_q, busy_d;

   // Next-state and datapath decode; the shared counter restarts on any state change.
   always_comb begin
      state_d = state_q;
      cnt_inc = 1'b0;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = 1'b0;
      last_d  = 1'b0;
      pkt_d   = pkt_q;
      tmo_d   = tmo_q;

      case (state_q)
         ST_IDLE: begin
            if (enable_in && short_preamble_detected) begin
               state_d = ST_WAIT_LONG;
            end
         end

         ST_WAIT_LONG: begin
            if (long_preamble_detected) begin
               state_d = ST_CAPTURE;
            end else if (!enable_in) begin
               state_d = ST_FLUSH;
            end else if (sample_in_valid) begin
               if (cnt_q == C_TMO_LAST) begin
                  state_d = ST_FLUSH;
                  if (tmo_q != 16'hFFFF) begin
                     tmo_d = tmo_q + 16'd1;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end

         ST_CAPTURE: begin
            if (sample_in_valid) begin
               valid_d = 1'b1;
               data_d  = sample_in;
               if (cnt_q == C_CAP_LAST) begin
                  last_d  = 1'b1;
                  pkt_d   = pkt_q + 16'd1;
                  state_d = enable_in ? ST_HOLDOFF : ST_FLUSH;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end

         ST_HOLDOFF: begin
            if (!enable_in) begin
               state_d = ST_FLUSH;
            end else if (sample_in_valid) begin
               if (cnt_q == C_HOLD_LAST) begin
                  state_d = ST_FLUSH;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end

         ST_FLUSH: begin
            // Counts clocks rather than samples so the detector reset width is fixed.
            if (cnt_q == C_SYNC_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_inc) begin
         cnt_d = cnt_q + C_CNT_ONE;
      end

      sync_d = (state_d == ST_FLUSH);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         pkt_q   <= '0;
         tmo_q   <= '0;
         sync_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         pkt_q   <= pkt_d;
         tmo_q   <= tmo_d;
         sync_q  <= sync_d;
         busy_q  <= busy_d;
      end
   end

   assign sync_rst_out       = sync_q;
   assign capture_sample_out = data_q;
   assign capture_valid_out  = valid_q;
   assign capture_last_out   = last_q;
   assign busy_out           = busy_q;
   assign state_out          = state_q;
   assign pkt_count_out      = pkt_q;
   assign timeout_count_out  = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_csi_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csi_capture_ctrl
// Brief    : Self-checking bench for csi_capture_ctrl (vector table, directed
//            corner sequences, randomized traffic against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_csi_capture_ctrl;

   localparam int LONG_TIMEOUT    = 320;
   localparam int CAPTURE_LEN     = 128;
   localparam int HOLDOFF         = 64;
   localparam int SYNC_RST_CYCLES = 4;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        enable_in = 1'b0;
   logic [31:0] sample_in = '0;
   logic        sample_in_valid = 1'b0;
   logic        short_preamble_detected = 1'b0;
   logic        long_preamble_detected = 1'b0;
   logic        sync_rst_out;
   logic [31:0] capture_sample_out;
   logic        capture_valid_out;
   logic        capture_last_out;
   logic        busy_out;
   logic [2:0]  state_out;
   logic [15:0] pkt_count_out;
   logic [15:0] timeout_count_out;

   csi_capture_ctrl #(
      .LONG_TIMEOUT    (LONG_TIMEOUT),
      .CAPTURE_LEN     (CAPTURE_LEN),
      .HOLDOFF         (HOLDOFF),
      .SYNC_RST_CYCLES (SYNC_RST_CYCLES)
   ) dut (
      .clk_in                  (clk_in),
      .rst_n_in                (rst_n_in),
      .enable_in               (enable_in),
      .sample_in               (sample_in),
      .sample_in_valid         (sample_in_valid),
      .short_preamble_detected (short_preamble_detected),
      .long_preamble_detected  (long_preamble_detected),
      .sync_rst_out            (sync_rst_out),
      .capture_sample_out      (capture_sample_out),
      .capture_valid_out       (capture_valid_out),
      .capture_last_out        (capture_last_out),
      .busy_out                (busy_out),
      .state_out               (state_out),
      .pkt_count_out           (pkt_count_out),
      .timeout_count_out       (timeout_count_out)
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;

   // Reference model: phase plus a 1-based count of what has been seen in it.
   int          m_phase = 0;
   int          m_seen  = 0;
   int          e_state = 0;
   bit          e_busy  = 0;
   bit          e_sync  = 0;
   bit          e_valid = 0;
   bit          e_last  = 0;
   logic [31:0] e_data  = '0;
   int          e_pkt   = 0;
   int          e_tmo   = 0;

   task automatic model_step();
      int  nxt;
      bit  fwd;
      bit  lst;
      nxt = m_phase;
      fwd = 0;
      lst = 0;
      if (m_phase == 0) begin
         if (enable_in && short_preamble_detected) nxt = 1;
      end else if (m_phase == 1) begin
         if (long_preamble_detected) nxt = 2;
         else if (!enable_in) nxt = 4;
         else if (sample_in_valid) begin
            m_seen++;
            if (m_seen == LONG_TIMEOUT) begin
               nxt = 4;
               if (e_tmo < 65535) e_tmo++;
            end
         end
      end else if (m_phase == 2) begin
         if (sample_in_valid) begin
            fwd = 1;
            e_data = sample_in;
            m_seen++;
            if (m_seen == CAPTURE_LEN) begin
               lst   = 1;
               e_pkt = (e_pkt + 1) % 65536;
               nxt   = enable_in ? 3 : 4;
            end
         end
      end else if (m_phase == 3) begin
         if (!enable_in) nxt = 4;
         else if (sample_in_valid) begin
            m_seen++;
            if (m_seen == HOLDOFF) nxt = 4;
         end
      end else begin
         m_seen++;
         if (m_seen == SYNC_RST_CYCLES) nxt = 0;
      end
      if (nxt != m_phase) m_seen = 0;
      m_phase = nxt;
      e_state = m_phase;
      e_busy  = (m_phase != 0);
      e_sync  = (m_phase == 4);
      e_valid = fwd;
      e_last  = lst;
   endtask

   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         m_phase = 0; m_seen = 0; e_state = 0; e_busy = 0; e_sync = 0;
         e_valid = 0; e_last = 0; e_data = '0; e_pkt = 0; e_tmo = 0;
      end else begin
         model_step();
      end
   end

   // Observation counters, cleared by each scenario.
   int          n_valid, n_last, n_sync, n_hold;
   logic [31:0] first_data, last_data;

   task automatic clr_obs();
      n_valid = 0; n_last = 0; n_sync = 0; n_hold = 0;
      first_data = '0; last_data = '0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      chk("state", 32'(state_out), 32'(e_state));
      chk("busy", 32'(busy_out), 32'(e_busy));
      chk("sync_rst", 32'(sync_rst_out), 32'(e_sync));
      chk("cap_valid", 32'(capture_valid_out), 32'(e_valid));
      chk("cap_last", 32'(capture_last_out), 32'(e_last));
      chk("pkt_count", 32'(pkt_count_out), 32'(e_pkt));
      chk("tmo_count", 32'(timeout_count_out), 32'(e_tmo));
      if (e_valid) chk("cap_data", capture_sample_out, e_data);
      if (capture_valid_out) begin
         n_valid++;
         if (n_valid == 1) first_data = capture_sample_out;
      end
      if (capture_last_out) begin
         n_last++;
         last_data = capture_sample_out;
      end
      if (sync_rst_out) n_sync++;
      if (state_out == 3'd3) n_hold++;
   endtask

   task automatic drive(input bit en, input bit sh, input bit lg, input bit v, input logic [31:0] s);
      enable_in               = en;
      short_preamble_detected = sh;
      long_preamble_detected  = lg;
      sample_in_valid         = v;
      sample_in               = s;
      tick();
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      enable_in = 1'b0; short_preamble_detected = 1'b0; long_preamble_detected = 1'b0;
      sample_in_valid = 1'b0; sample_in = '0;
      tick();
      tick();
      chk("rst_data", capture_sample_out, 32'h0);
      chk("rst_state", 32'(state_out), 32'd0);
      rst_n_in = 1'b1;
      clr_obs();
   endtask

   typedef struct {
      bit       en;
      bit       sh;
      bit       lg;
      bit       v;
      bit [2:0] st;
      bit       sync;
      bit       busy;
   } vec_t;

   vec_t tbl[12];

   initial begin
      // {enable, short, long, valid} -> {state, sync_rst, busy} after the edge
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1};

      clr_obs();
      do_reset();
      chk("rst_pkt", 32'(pkt_count_out), 32'd0);
      chk("rst_tmo", 32'(timeout_count_out), 32'd0);
      chk("rst_valid", 32'(capture_valid_out), 32'd0);

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].en, tbl[i].sh, tbl[i].lg, tbl[i].v, 32'(i));
         chk("tbl_state", 32'(state_out), 32'(tbl[i].st));
         chk("tbl_sync", 32'(sync_rst_out), 32'(tbl[i].sync));
         chk("tbl_busy", 32'(busy_out), 32'(tbl[i].busy));
      end

      // T1 happy path
      do_reset();
      drive(1, 1, 0, 0, 0);
      repeat (40) drive(1, 0, 0, 1, $urandom);
      drive(1, 0, 1, 1, 32'hDEAD_BEEF);
      for (int k = 1; k <= 200; k++) drive(1, 0, 0, 1, 32'h1000_0000 + 32'(k));
      repeat (10) drive(1, 0, 0, 0, 0);
      chk("t1_nvalid", 32'(n_valid), 32'd128);
      chk("t1_nlast", 32'(n_last), 32'd1);
      chk("t1_first", first_data, 32'h1000_0001);
      chk("t1_lastdata", last_data, 32'h1000_0080);
      chk("t1_pkt", 32'(pkt_count_out), 32'd1);
      chk("t1_holdoff", 32'(n_hold), 32'd64);
      chk("t1_sync", 32'(n_sync), 32'd4);
      chk("t1_idle", 32'(state_out), 32'd0);

      // T2 timeout
      do_reset();
      drive(1, 1, 0, 0, 0);
      for (int i = 1; i <= LONG_TIMEOUT; i++) begin
         drive(1, 0, 0, 1, $urandom);
         if (i == LONG_TIMEOUT - 1) chk("t2_wait", 32'(state_out), 32'd1);
         if (i == LONG_TIMEOUT) chk("t2_flush", 32'(state_out), 32'd4);
      end
      repeat (8) drive(1, 0, 0, 0, 0);
      chk("t2_tmo", 32'(timeout_count_out), 32'd1);
      chk("t2_nvalid", 32'(n_valid), 32'd0);
      chk("t2_pkt", 32'(pkt_count_out), 32'd0);
      chk("t2_idle", 32'(state_out), 32'd0);

      // T3 long pulse coincides with the final timeout sample
      do_reset();
      drive(1, 1, 0, 0, 0);
      repeat (LONG_TIMEOUT - 1) drive(1, 0, 0, 1, $urandom);
      drive(1, 0, 1, 1, 32'hCAFE_0000);
      chk("t3_capture", 32'(state_out), 32'd2);
      chk("t3_tmo", 32'(timeout_count_out), 32'd0);
      repeat (200) drive(1, 0, 0, 1, $urandom);
      repeat (10) drive(1, 0, 0, 0, 0);
      chk("t3_nvalid", 32'(n_valid), 32'd128);
      chk("t3_pkt", 32'(pkt_count_out), 32'd1);

      // T4 enable drop mid-capture
      do_reset();
      drive(1, 1, 0, 0, 0);
      repeat (5) drive(1, 0, 0, 1, $urandom);
      drive(1, 0, 1, 0, 0);
      for (int k = 1; k <= CAPTURE_LEN; k++) drive(k < 50, 0, 0, 1, 32'h4000_0000 + 32'(k));
      repeat (10) drive(0, 0, 0, 0, 0);
      chk("t4_nvalid", 32'(n_valid), 32'd128);
      chk("t4_nlast", 32'(n_last), 32'd1);
      chk("t4_noholdoff", 32'(n_hold), 32'd0);
      chk("t4_sync", 32'(n_sync), 32'd4);
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      chk("t4_noarm", 32'(state_out), 32'd0);

      // T5 gapped input, pulses during HOLDOFF/FLUSH
      do_reset();
      drive(1, 1, 0, 0, 0);
      drive(1, 0, 1, 0, 0);
      for (int c = 0; c < 384; c++) drive(1, 0, 0, (c % 3) == 0, $urandom);
      chk("t5_nvalid", 32'(n_valid), 32'd128);
      chk("t5_holdoff", 32'(state_out), 32'd3);
      for (int c = 0; c < 68; c++) drive(1, (c % 5) == 0, (c % 7) == 0, 1, $urandom);
      chk("t5_idle", 32'(state_out), 32'd0);
      chk("t5_pkt", 32'(pkt_count_out), 32'd1);
      chk("t5_nvalid2", 32'(n_valid), 32'd128);

      // T6 reset mid-capture
      do_reset();
      drive(1, 1, 0, 0, 0);
      drive(1, 0, 1, 0, 0);
      repeat (60) drive(1, 0, 0, 1, $urandom);
      rst_n_in = 1'b0;
      #1;
      chk("t6_valid", 32'(capture_valid_out), 32'd0);
      chk("t6_state", 32'(state_out), 32'd0);
      chk("t6_pkt", 32'(pkt_count_out), 32'd0);
      chk("t6_busy", 32'(busy_out), 32'd0);
      tick();
      rst_n_in = 1'b1;
      repeat (100) drive(1, 0, 0, 1, $urandom);
      chk("t6_nolast", 32'(n_last), 32'd0);
      chk("t6_idle", 32'(state_out), 32'd0);

      // Randomized traffic checked cycle by cycle against the model
      do_reset();
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 1499) == 0) begin
            rst_n_in = 1'b0;
            tick();
            rst_n_in = 1'b1;
         end else begin
            drive($urandom_range(0, 15) != 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
